// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    localparam int unsigned PC_STEP32 = 4;
    localparam int unsigned PC_STEP16 = 2;

    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request handshake between pc_gen (master) and instruction memory (slave).
// With PC_RVC_EN defined the slave also reports whether the fetched instruction is 16-bit.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
) ();

    logic [XLEN-1:0] pc_o;
    logic            fetch_valid_o;
    logic            fetch_ready_i;
`ifdef PC_RVC_EN
    logic            insn_len16_i;

    modport master (output pc_o, output fetch_valid_o, input fetch_ready_i, input insn_len16_i);
    modport slave  (input pc_o, input fetch_valid_o, output fetch_ready_i, output insn_len16_i);
`else
    modport master (output pc_o, output fetch_valid_o, input fetch_ready_i);
    modport slave  (input pc_o, input fetch_valid_o, output fetch_ready_i);
`endif

endinterface

// File: rtl/pc_align_chk.sv
// Redirect-target alignment check: 2-byte with PC_RVC_EN defined, 4-byte otherwise.
module pc_align_chk #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] target,
    output logic            misaligned
);

`ifdef PC_RVC_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
`endif

    assign misaligned = |(target & ALIGN_MASK);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: trap > jump > hold > advance, all outputs registered.
// Optional compressed-instruction support via PC_RVC_EN (2-byte step and alignment).
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(PC_RESET_ADDR),
    parameter int unsigned     HOLD_W     = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              jump_flag_i,
    input  logic [XLEN-1:0]   jump_addr_i,
    input  logic              trap_flag_i,
    input  logic [XLEN-1:0]   trap_addr_i,
    pc_gen_if.master          fetch,
    output logic              redirect_o,
    output logic              misalign_o,
    output logic [XLEN-1:0]   misalign_addr_o
);

`ifdef PC_RVC_EN
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(1);
`else
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);
`endif
    // Keep the PC aligned from reset on, so pc_o low bits never carry garbage.
    localparam logic [XLEN-1:0] RESET_PC = RESET_ADDR & ~LOW_MASK;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            redirect_d;
    logic            misalign_d;
    logic [XLEN-1:0] misalign_addr_d;

    logic            hold;
    logic            redir_req;
    logic [XLEN-1:0] target;
    logic            target_misaligned;
    logic [XLEN-1:0] step;

    assign hold      = |hold_flag_i;
    assign redir_req = trap_flag_i | jump_flag_i;
    assign target    = trap_flag_i ? trap_addr_i : jump_addr_i;

`ifdef PC_RVC_EN
    assign step = fetch.insn_len16_i ? XLEN'(PC_STEP16) : XLEN'(PC_STEP32);
`else
    assign step = XLEN'(PC_STEP32);
`endif

    pc_align_chk #(.XLEN(XLEN)) u_align_chk (
        .target     (target),
        .misaligned (target_misaligned)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_PC;
            valid_q         <= 1'b0;
            redirect_o      <= 1'b0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            valid_q         <= valid_d;
            redirect_o      <= redirect_d;
            misalign_o      <= misalign_d;
            misalign_addr_o <= misalign_addr_d;
        end
    end

    // Next state / next PC; a rejected (misaligned) redirect still consumes the cycle.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_d      = 1'b0;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_o;

        if (redir_req) begin
            state_d = hold ? ST_HOLD : ST_RUN;
            if (target_misaligned) begin
                misalign_d      = 1'b1;
                misalign_addr_d = target;
            end else begin
                pc_d       = target;
                redirect_d = 1'b1;
            end
        end else if (hold) begin
            state_d = ST_HOLD;
        end else begin
            unique case (state_q)
                ST_BOOT, ST_HOLD: state_d = ST_RUN;
                ST_RUN: begin
                    if (valid_q && fetch.fetch_ready_i) begin
                        pc_d = pc_q + step;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end

        valid_d = (state_d == ST_RUN);
    end

    assign fetch.pc_o          = pc_q;
    assign fetch.fetch_valid_o = valid_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the core. It holds the fetch address and drives it to instruction memory and the IF/ID register through a valid/ready handshake. It takes redirects from ctrl (jump) and from the CSR/trap unit (trap), and stalls on the ctrl hold flag. It also checks redirect-target alignment and, optionally, steps by 2 for compressed instructions.

## Interface
- XLEN, 32, address width in bits.
- RESET_ADDR, 0, value loaded into the PC on reset.
- HOLD_W, 2, width of the ctrl hold flag.
- clk  in  1  core clock.
- rstn  in  1  reset, asynchronous, active-low.
- hold_flag_i  in  HOLD_W  ctrl stall request; any nonzero value holds the PC.
- jump_flag_i  in  1  ctrl branch/jump redirect.
- jump_addr_i  in  XLEN  jump target.
- trap_flag_i  in  1  trap/mret redirect from the CSR unit.
- trap_addr_i  in  XLEN  trap target (mtvec/mepc).
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle.
- insn_len16_i  in  1  the instruction at pc_o is 16-bit. Present only with PC_RVC_EN.
- pc_o  out  XLEN  current fetch address.
- fetch_valid_o  out  1  pc_o is a valid fetch request.
- redirect_o  out  1  one-cycle pulse: pc_o was loaded by a redirect on the previous edge.
- misalign_o  out  1  one-cycle pulse: the redirect target was misaligned.
- misalign_addr_o  out  XLEN  offending target, valid while misalign_o=1.

## Operation
**States**
- BOOT: fetch_valid_o=0. Always moves to RUN on the next edge.
- RUN: fetch_valid_o=1.
- HOLD: fetch_valid_o=0.

**State transitions**
- RUN→HOLD and BOOT→HOLD when hold_flag_i≠0.
- HOLD→RUN when hold_flag_i=0.

**Priority each edge:** trap > jump > hold > advance.
- **Trap:** load trap_addr_i into the PC. Set redirect_o=1 on the next cycle. This applies in any state, ignores hold and fetch_ready_i, and moves BOOT to RUN unless hold is asserted.
- **Jump:** same as trap, using jump_addr_i. Ignored when trap_flag_i=1 in the same cycle.
- **Misaligned redirect target:** the PC is not updated and redirect_o stays 0. Set misalign_o=1 and misalign_addr_o=target on the next cycle. A target is misaligned when:
  - without PC_RVC_EN: bits [1:0]≠0;
  - with PC_RVC_EN: bit 0≠0.
  The trap unit is responsible for issuing the trap redirect that follows.
- **Hold:** the PC is unchanged and the state goes to HOLD.
- **Advance:** only when in RUN and fetch_valid_o && fetch_ready_i. The PC becomes PC + step (4, or 2 when PC_RVC_EN and insn_len16_i=1), computed modulo 2^XLEN; 0xFFFF_FFFC+4 = 0.
- **RUN without fetch_ready_i:** the PC and fetch_valid_o are unchanged. pc_o must stay stable until it is accepted.

## Timing
- **Reset values:** pc_o=RESET_ADDR, fetch_valid_o=0, redirect_o=0, misalign_o=0, misalign_addr_o=0, state=BOOT.
- **Register outputs:** every output is a register; there is no combinational path from input to output.
- **Redirect latency:** one cycle. A redirect sampled at edge N is visible on pc_o after edge N, with redirect_o high for that single cycle.
- **First fetch:** fetch_valid_o rises one cycle after reset deassertion (BOOT lasts exactly one cycle).
- **Hold:** fetch_valid_o drops on the edge after hold_flag_i goes nonzero and rises on the edge after it clears.
- **Redirect during hold:** the PC is updated and fetching resumes at the new address once hold clears.
- **Reset asserted mid-operation:** immediately restores all reset values, regardless of pending handshakes.
- **Back-to-back redirects:** each one takes effect. The last edge wins, and redirect_o stays high continuously.

## Configuration
- **PC_RVC_EN defined:**
  - the insn_len16_i port exists;
  - step is 2 or 4;
  - redirect alignment is 2-byte.
- **PC_RVC_EN undefined:**
  - no insn_len16_i port;
  - step is fixed at 4;
  - redirect alignment is 4-byte;
  - pc_o[1:0] is constant 0.

## Structure
- **Shared package pc_pkg:**
  - state encoding (BOOT/RUN/HOLD);
  - step constants (PC_STEP32=4, PC_STEP16=2);
  - default RESET_ADDR.
- **Sub-module pc_align_chk:** combinational. Inputs: target. Outputs: misaligned flag. Compile-time alignment set by PC_RVC_EN.

## Test plan
1. RESET_ADDR=0x8000_0000, fetch_ready_i=1 constant → after reset pc_o=0x8000_0000 with valid=0 for one cycle, then 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive cycles.
2. fetch_ready_i low for 3 cycles at pc=0x10 → pc_o holds 0x10 with valid=1, then advances to 0x14 on the accept edge.
3. trap_flag_i (0x100) and jump_flag_i (0x200) in the same cycle with hold_flag_i=2'b01 → pc_o=0x100, redirect_o pulses once, valid=0 until hold clears, then fetch starts at 0x100.
4. jump_addr_i=0x202 without PC_RVC_EN → pc unchanged, misalign_o=1 and misalign_addr_o=0x202 for one cycle, redirect_o=0. With PC_RVC_EN the same jump is taken normally.
5. PC_RVC_EN, pc=0xFFFF_FFFC, insn_len16_i sequence 1,1,0 with ready=1 → pc_o goes 0xFFFF_FFFE, 0x0000_0000, 0x0000_0004 (wrap).
6. rstn asserted while in HOLD with a jump pending → all outputs return to reset values immediately, then BOOT→RUN from RESET_ADDR.
